// File: rtl/rr_arbiter_pkg.sv
// ============================================================================
// Module   : rr_arbiter_pkg
// Brief    : Shared state encoding for the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter_pkg;

    typedef enum logic [0:0] {
        RR_IDLE = 1'b0,
        RR_OWN  = 1'b1
    } rr_state_t;

    // Advance a requester index by one with wrap at n (n need not be a power of two).
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage : rr_arbiter_pkg

`default_nettype wire

// File: rtl/rr_arbiter_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotating-priority search over a doubled request vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 8,
    parameter int ENC_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [ENC_W-1:0] i_ptr,
    output logic [N-1:0]     o_pick,
    output logic [ENC_W-1:0] o_idx,
    output logic             o_any
);

    logic [2*N-1:0] w_req2;
    logic [2*N-1:0] w_hit;
    logic           w_found;

    // Masking the lower copy below ptr makes the first hit the next requester in rotation.
    always_comb begin
        w_req2  = {i_req, i_req};
        w_hit   = '0;
        w_found = 1'b0;
        o_pick  = '0;
        o_idx   = '0;
        for (int j = 0; j < 2 * N; j++) begin
            w_hit[j] = w_req2[j] && (j >= int'(i_ptr));
        end
        for (int j = 0; j < 2 * N; j++) begin
            if (!w_found && w_hit[j]) begin
                w_found        = 1'b1;
                o_idx          = ENC_W'(j % N);
                o_pick[j % N]  = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter with lock and optional weighted bursts
//            (enable with macro RR_ARBITER_WEIGHT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int WT_W  = 4,
    localparam int ENC_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      lock,
    input  logic [N*WT_W-1:0] weight,
    output logic [N-1:0]      grant,
    output logic [ENC_W-1:0]  grant_enc,
    output logic              grant_vld
);

    localparam logic [ENC_W-1:0] c_LAST = ENC_W'(N - 1);

    rr_state_t        r_state,  w_nxt_state;
    logic [N-1:0]     r_grant,  w_nxt_grant;
    logic [ENC_W-1:0] r_enc,    w_nxt_enc;
    logic [ENC_W-1:0] r_ptr,    w_nxt_ptr;
    logic [ENC_W-1:0] w_inc_ptr;
    logic [ENC_W-1:0] w_pick_ptr;
    logic [N-1:0]     w_pick;
    logic [ENC_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_cnt_zero;

    assign w_inc_ptr  = (r_enc == c_LAST) ? '0 : r_enc + 1'b1;
    assign w_pick_ptr = (r_state == RR_OWN) ? w_inc_ptr : r_ptr;

    rr_pick #(
        .N     (N),
        .ENC_W (ENC_W)
    ) u_pick (
        .i_req  (req),
        .i_ptr  (w_pick_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

`ifdef RR_ARBITER_WEIGHT_EN
    logic [WT_W-1:0] r_cnt, w_nxt_cnt, w_quota;

    // A zero weight still earns one cycle of ownership.
    always_comb begin
        w_quota = '0;
        for (int k = 0; k < N; k++) begin
            if (w_pick_idx == ENC_W'(k)) begin
                w_quota = (weight[k*WT_W +: WT_W] == '0) ? '0 : weight[k*WT_W +: WT_W] - 1'b1;
            end
        end
    end

    assign w_cnt_zero = (r_cnt == '0);
`else
    logic w_unused_weight;
    assign w_unused_weight = ^weight;
    assign w_cnt_zero      = 1'b1;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_enc   = r_enc;
        w_nxt_ptr   = r_ptr;
`ifdef RR_ARBITER_WEIGHT_EN
        w_nxt_cnt   = r_cnt;
`endif
        case (r_state)
            RR_IDLE: begin
                if (w_pick_any) begin
                    w_nxt_state = RR_OWN;
                    w_nxt_grant = w_pick;
                    w_nxt_enc   = w_pick_idx;
`ifdef RR_ARBITER_WEIGHT_EN
                    w_nxt_cnt   = w_quota;
`endif
                end
            end
            RR_OWN: begin
                if (lock[r_enc]) begin
                    w_nxt_state = RR_OWN;
                end else if (req[r_enc] && !w_cnt_zero) begin
`ifdef RR_ARBITER_WEIGHT_EN
                    w_nxt_cnt   = r_cnt - 1'b1;
`endif
                end else begin
                    // Release and hand over at the same edge; the old owner ranks last.
                    w_nxt_ptr = w_inc_ptr;
                    if (w_pick_any) begin
                        w_nxt_grant = w_pick;
                        w_nxt_enc   = w_pick_idx;
`ifdef RR_ARBITER_WEIGHT_EN
                        w_nxt_cnt   = w_quota;
`endif
                    end else begin
                        w_nxt_state = RR_IDLE;
                        w_nxt_grant = '0;
`ifdef RR_ARBITER_WEIGHT_EN
                        w_nxt_cnt   = '0;
`endif
                    end
                end
            end
            default: begin
                w_nxt_state = RR_IDLE;
                w_nxt_grant = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RR_IDLE;
            r_grant <= '0;
            r_enc   <= '0;
            r_ptr   <= '0;
`ifdef RR_ARBITER_WEIGHT_EN
            r_cnt   <= '0;
`endif
        end else if (ce) begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_enc   <= w_nxt_enc;
            r_ptr   <= w_nxt_ptr;
`ifdef RR_ARBITER_WEIGHT_EN
            r_cnt   <= w_nxt_cnt;
`endif
        end
    end

    assign grant     = r_grant;
    assign grant_enc = r_enc;
    assign grant_vld = (r_state == RR_OWN);

endmodule : rr_arbiter

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
// Module   : tb_rr_arbiter
// Brief    : Directed table-driven bench for rr_arbiter (N=8 and N=5 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [7:0]  req, lock;
    logic [31:0] weight;
    logic [7:0]  grant;
    logic [2:0]  grant_enc;
    logic        grant_vld;

    logic [4:0]  req5, lock5;
    logic [19:0] weight5;
    logic [4:0]  grant5;
    logic [2:0]  grant_enc5;
    logic        grant_vld5;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] lock;
        logic [7:0] grant;
        logic [2:0] enc;
        logic       vld;
    } vec_t;

    vec_t tbl [13];

    rr_arbiter #(.N(8), .WT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .req       (req),
        .lock      (lock),
        .weight    (weight),
        .grant     (grant),
        .grant_enc (grant_enc),
        .grant_vld (grant_vld)
    );

    rr_arbiter #(.N(5), .WT_W(4)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .req       (req5),
        .lock      (lock5),
        .weight    (weight5),
        .grant     (grant5),
        .grant_enc (grant_enc5),
        .grant_vld (grant_vld5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] g, input logic [2:0] e, input logic v);
        chk({name, "_grant"}, 32'(grant), 32'(g));
        chk({name, "_enc"},   32'(grant_enc), 32'(e));
        chk({name, "_vld"},   32'(grant_vld), 32'(v));
    endtask

    logic [2:0] exp_w [6];
    logic [2:0] exp_f [3];

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{8'h81, 8'h00, 8'h01, 3'd0, 1'b1};
        tbl[2]  = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b1};
        tbl[3]  = '{8'h81, 8'h00, 8'h01, 3'd0, 1'b1};
        tbl[4]  = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b1};
        tbl[5]  = '{8'h00, 8'h00, 8'h00, 3'd7, 1'b0};
        tbl[6]  = '{8'h10, 8'h00, 8'h10, 3'd4, 1'b1};
        tbl[7]  = '{8'h10, 8'h10, 8'h10, 3'd4, 1'b1};
        tbl[8]  = '{8'h00, 8'h10, 8'h10, 3'd4, 1'b1};
        tbl[9]  = '{8'h18, 8'h08, 8'h08, 3'd3, 1'b1};
        tbl[10] = '{8'h18, 8'h00, 8'h10, 3'd4, 1'b1};
        tbl[11] = '{8'h00, 8'h00, 8'h00, 3'd4, 1'b0};
        tbl[12] = '{8'h3F, 8'h00, 8'h20, 3'd5, 1'b1};

        rst_n   = 1'b0;
        ce      = 1'b1;
        req     = '0;
        lock    = '0;
        weight  = {8{4'h1}};
        req5    = '0;
        lock5   = '0;
        weight5 = {5{4'h1}};

        #12;
        chk8("reset", 8'h00, 3'd0, 1'b0);
        chk("reset5_grant", 32'(grant5), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            req  = tbl[i].req;
            lock = tbl[i].lock;
            cyc();
            chk8($sformatf("row%0d", i), tbl[i].grant, tbl[i].enc, tbl[i].vld);
        end

        // Owner 5 locked with its request dropped
        req  = 8'h00;
        lock = 8'h20;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("lock%0d_grant", i), 32'(grant), 32'h20);
        end
        lock = 8'h00;
        cyc();
        chk8("unlock", 8'h00, 3'd5, 1'b0);
        req = 8'hFF;
        cyc();
        chk8("ptr6", 8'h40, 3'd6, 1'b1);

        // Clock enable low freezes everything
        ce  = 1'b0;
        req = 8'h01;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk8($sformatf("ce%0d", i), 8'h40, 3'd6, 1'b1);
        end
        ce   = 1'b1;
        req  = 8'h40;
        lock = 8'h40;
        cyc();
        chk8("ce_resume", 8'h40, 3'd6, 1'b1);

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk8("async_rst", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        lock  = 8'h00;
        cyc();
        chk8("post_rst", 8'h01, 3'd0, 1'b1);

        // N=5 wrap
        req5 = 5'h1F;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("n5_%0d_enc", i), 32'(grant_enc5), 32'(i % 5));
            chk($sformatf("n5_%0d_vld", i), 32'(grant_vld5), 32'h1);
        end
        req5 = '0;

        // Weighted bursts: weight[2]=3, weight[3]=2
`ifdef RR_ARBITER_WEIGHT_EN
        exp_w = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
        exp_f = '{3'd2, 3'd2, 3'd3};
`else
        exp_w = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3};
        exp_f = '{3'd2, 3'd3, 3'd2};
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        weight = 32'h1111_2311;
        req    = 8'h0C;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("wt%0d_enc", i), 32'(grant_enc), 32'(exp_w[i]));
        end
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("wtfrz%0d_enc", i), 32'(grant_enc), 32'(exp_w[5]));
        end
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("wtres%0d_enc", i), 32'(grant_enc), 32'(exp_f[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter

`default_nettype wire

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 8, number of requesters (2..32, need not be a power of two).
REQ-002 Parameter WT_W, default 4, width of each per-requester weight field.
REQ-003 Localparam ENC_W = $clog2(N), width of the encoded grant.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ce  input  1  clock enable; when low, all state is frozen.
REQ-007 req  input  N  request lines, one per requester.
REQ-008 lock  input  N  lock lines; lock[i] holds the grant while requester i owns it.
REQ-009 weight  input  N*WT_W  burst quota per requester; field i is weight[i*WT_W +: WT_W].
REQ-010 grant  output  N  registered one-hot grant, or all zero.
REQ-011 grant_enc  output  ENC_W  registered index of the current owner.
REQ-012 grant_vld  output  1  registered; high when grant is non-zero.

Function
REQ-013 The block SHALL keep a priority pointer ptr (ENC_W bits) and SHALL pick the first asserted req at index ptr, ptr+1, ... N-1, 0, ... ptr-1, in that order.
REQ-014 The block SHALL implement two states: IDLE (no owner) and OWN (one owner i, remaining-quota counter cnt of WT_W bits).
REQ-015 IDLE with ce=1 and any req: grant SHALL go one-hot on the picked i at the next edge, with grant_enc=i, grant_vld=1, state=OWN, and cnt=max(weight[i],1)-1; latency from req to grant is one cycle.
REQ-016 IDLE with no req: outputs SHALL stay zero and ptr SHALL be unchanged.
REQ-017 OWN, lock[i]=1: grant SHALL hold and cnt SHALL not change, regardless of req[i].
REQ-018 OWN, lock[i]=0, req[i]=1, cnt!=0: grant SHALL hold and cnt SHALL decrement by 1.
REQ-019 OWN, lock[i]=0, and either req[i]=0 or cnt=0: the grant SHALL be released and ptr SHALL be set to (i+1) mod N.
REQ-020 On release, if any req is asserted, the next owner SHALL be picked from the new pointer (i last) and granted at the same edge, with no idle bubble; otherwise the block SHALL enter IDLE with grant=0, grant_vld=0, and grant_enc holding its last value.
REQ-021 Pointer wrap SHALL be modulo N for non-power-of-two N; for i=N-1, ptr SHALL become 0.
REQ-022 grant SHALL never have more than one bit set, and grant_enc SHALL always equal the index of the set bit while grant_vld=1.
REQ-023 Lock bits of non-owners SHALL be ignored.
REQ-024 Changes on req, lock, or weight while ce=0 SHALL have no effect until a ce=1 edge.

Reset
REQ-025 While rst_n=0, asynchronously: grant=0, grant_enc=0, grant_vld=0, ptr=0, cnt=0, state=IDLE.
REQ-026 Reset asserted during OWN SHALL drop the grant immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, the first arbitration SHALL start from index 0.

Configuration
REQ-028 Macro RR_ARBITER_WEIGHT_EN, when defined, SHALL enable weighted bursts as specified in REQ-015 and REQ-018.
REQ-029 Without RR_ARBITER_WEIGHT_EN, the weight port SHALL remain present but be ignored, cnt SHALL be absent, and every unlocked grant SHALL last exactly one ce cycle (pure round robin).

Structure
REQ-030 Package rr_arbiter_pkg SHALL hold the state enum (RR_IDLE, RR_OWN) and any shared width helper.
REQ-031 Sub-module rr_pick (combinational, parameter N) SHALL take req and ptr and return a one-hot pick plus its index, using a double-width masked priority search.

Verification
REQ-032 N=8, reset, then req=8'h81 with weights 1 -> grants to 0, then 7, then 0, ... on consecutive cycles, with grant_vld held high.
REQ-033 N=5, req=5'h1F, weights 1 -> grant_enc sequence 0,1,2,3,4,0 (wrap at 4).
REQ-034 Weight EN, weight[2]=3, req=8'h0C held -> owner 2 for 3 cycles, then owner 3 for weight[3] cycles.
REQ-035 Owner 5 with lock[5]=1 and req[5] dropped for 10 cycles -> grant stays 8'h20; lock cleared -> released next edge, ptr=6.
REQ-036 ce=0 for 4 cycles while in OWN -> outputs and cnt are frozen; rst_n pulsed low mid-cycle -> grant=0 before the next edge.
